code_guess_controller: RTL and testbench
========================================

# code_guess_controller

Sequencer for the code-guessing datapath: it enables and samples the free-running 8-bit LFSR code generator to arm a secret code, accepts user guesses over a valid/ready handshake, compares each guess against the secret, and enforces a limited number of attempts followed by a timed lockout. It sits between the LFSR code generator and the user-input and display logic of the lock design.

## Interface
- MAX_TRIES, 3, wrong guesses allowed per round (≥1)
- LOCKOUT_CYCLES, 16, clock cycles spent in lockout before returning to idle (≥1)
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- start  in  1  level; request a new round (arm a new code)
- rand_in  in  8  current LFSR output
- lfsr_enable  out  1  advance enable to the LFSR generator
- guess_valid  in  1  guess presented
- guess  in  8  guessed code
- guess_ready  out  1  controller accepts a guess this cycle
- result_valid  out  1  one-cycle pulse: compare result is valid
- match  out  1  last compared guess equaled the secret
- too_high / too_low  out  1 each  hint for the last compared guess
- unlocked  out  1  level, round won
- locked_out  out  1  level, lockout active
- tries_left  out  $clog2(MAX_TRIES+1)  remaining attempts

## Operation
- States: IDLE, ARM, WAIT_GUESS, CHECK, UNLOCKED, LOCKOUT.
- IDLE: lfsr_enable=1; start=1 -> ARM.
- ARM: lfsr_enable=1; if rand_in≠8'h00, secret<=rand_in, tries_left<=MAX_TRIES, -> WAIT_GUESS; if rand_in==8'h00, stay in ARM (zero is never a valid secret).
- WAIT_GUESS: lfsr_enable=0, guess_ready=1; guess_valid=1 -> latch guess, -> CHECK. start=1 -> ARM (abort round); start wins over a simultaneous guess_valid, and that guess is dropped.
- CHECK: guess_ready=0; register match=(guess==secret), hints, result_valid=1, tries_left<=tries_left-1. Next state: match -> UNLOCKED; else tries_left==1 (last try) -> LOCKOUT; else -> WAIT_GUESS.
- The tries_left decrement applies to every compare, including the matching one. tries_left saturates at 0 and never wraps.
- UNLOCKED: unlocked=1, lfsr_enable=1; start=1 -> ARM.
- LOCKOUT: locked_out=1, lfsr_enable=1; down-counter loaded with LOCKOUT_CYCLES-1 on entry; start is ignored; on counter==0 -> IDLE.
- match and the hint outputs hold their values until the next CHECK or the next ARM; entry to ARM clears them to 0.
- The secret is never driven on any output.

## Timing
- All outputs are registered. Reset values: state IDLE, lfsr_enable=1, guess_ready=0, result_valid=0, match=0, too_high=0, too_low=0, unlocked=0, locked_out=0, tries_left=0, secret=8'h00.
- Reset is asynchronous: asserting reset in any state forces the reset values immediately. The first state update after deassertion occurs on the following clk edge.
- start sampled at edge N in IDLE -> ARM during N+1. With nonzero rand_in at edge N+1, guess_ready=1 from cycle N+2.
- Guess handshake at edge M -> CHECK during M+1. result_valid, match and hints are high/valid during M+2, and guess_ready is reasserted in M+2 if the next state is WAIT_GUESS.
- Minimum spacing between accepted guesses is 2 cycles.
- Lockout lasts exactly LOCKOUT_CYCLES cycles with locked_out=1, then IDLE.

## Configuration
- HINT_EN defined: too_high=(guess>secret) and too_low=(guess<secret), both unsigned, registered in CHECK.
- HINT_EN undefined: too_high and too_low are tied to 0, and the magnitude comparator is not built.

## Test plan
- Reset low, release, start=1 with rand_in=8'hA5 -> ARM, then WAIT_GUESS with guess_ready=1 two cycles after start, tries_left=3.
- Secret 8'hA5, guess 8'hA5 -> result_valid pulse two cycles after the handshake, match=1, unlocked=1, tries_left=2; next start re-arms and match clears.
- Secret 8'hA5, guesses 8'h10 then 8'hF0 (HINT_EN) -> too_low=1 then too_high=1, tries_left 2 then 1, match=0. Without HINT_EN, both hints stay 0.
- Three wrong guesses -> locked_out=1 for exactly 16 cycles with start held high (ignored), then IDLE with lfsr_enable=1.
- rand_in=8'h00 for 3 cycles in ARM, then 8'h3C -> remains in ARM for 3 cycles, then arms; guess 8'h3C matches.
- start and guess_valid asserted together in WAIT_GUESS -> ARM, no result_valid pulse. Reset asserted mid-CHECK -> all outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/code_guess_controller.sv
// Round sequencer for the code lock: arms a nonzero LFSR secret, checks guesses, enforces tries and lockout.
// Optional magnitude hints are built only when HINT_EN is defined; all outputs are registered.
module code_guess_controller #(
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           start_i,
  input  logic [7:0]                     rand_in_i,
  output logic                           lfsr_enable_o,
  input  logic                           guess_valid_i,
  input  logic [7:0]                     guess_i,
  output logic                           guess_ready_o,
  output logic                           result_valid_o,
  output logic                           match_o,
  output logic                           too_high_o,
  output logic                           too_low_o,
  output logic                           unlocked_o,
  output logic                           locked_out_o,
  output logic [$clog2(MAX_TRIES+1)-1:0] tries_left_o
);

  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam int CW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ARM      = 3'd1;
  localparam logic [2:0] S_WAIT     = 3'd2;
  localparam logic [2:0] S_CHECK    = 3'd3;
  localparam logic [2:0] S_UNLOCKED = 3'd4;
  localparam logic [2:0] S_LOCKOUT  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [7:0]    secret_q, secret_d;
  logic [7:0]    guess_q, guess_d;
  logic [TW-1:0] tries_q, tries_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rv_q, rv_d;
  logic          match_q, match_d;
  logic          lfsr_en_q, ready_q, unlocked_q, locked_q;

  always_comb begin
    state_d  = state_q;
    secret_d = secret_q;
    guess_d  = guess_q;
    tries_d  = tries_q;
    cnt_d    = cnt_q;
    rv_d     = 1'b0;
    match_d  = match_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_ARM;
      end
      S_ARM: begin
        // Zero is reserved as "no secret", so keep sampling until the LFSR moves off it.
        if (rand_in_i != 8'h00) begin
          secret_d = rand_in_i;
          tries_d  = TW'(MAX_TRIES);
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (start_i) begin
          state_d = S_ARM;
        end else if (guess_valid_i) begin
          guess_d = guess_i;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        rv_d    = 1'b1;
        match_d = (guess_q == secret_q);
        tries_d = (tries_q != '0) ? tries_q - 1'b1 : '0;
        if (match_d) begin
          state_d = S_UNLOCKED;
        end else if (tries_q <= TW'(1)) begin
          state_d = S_LOCKOUT;
          cnt_d   = CW'(LOCKOUT_CYCLES - 1);
        end else begin
          state_d = S_WAIT;
        end
      end
      S_UNLOCKED: begin
        if (start_i) state_d = S_ARM;
      end
      S_LOCKOUT: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_ARM) match_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      secret_q   <= 8'h00;
      guess_q    <= 8'h00;
      tries_q    <= '0;
      cnt_q      <= '0;
      rv_q       <= 1'b0;
      match_q    <= 1'b0;
      lfsr_en_q  <= 1'b1;
      ready_q    <= 1'b0;
      unlocked_q <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      secret_q   <= secret_d;
      guess_q    <= guess_d;
      tries_q    <= tries_d;
      cnt_q      <= cnt_d;
      rv_q       <= rv_d;
      match_q    <= match_d;
      lfsr_en_q  <= (state_d != S_WAIT) && (state_d != S_CHECK);
      ready_q    <= (state_d == S_WAIT);
      unlocked_q <= (state_d == S_UNLOCKED);
      locked_q   <= (state_d == S_LOCKOUT);
    end
  end

`ifdef HINT_EN
  logic high_q, low_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      high_q <= 1'b0;
      low_q  <= 1'b0;
    end else if (state_d == S_ARM) begin
      high_q <= 1'b0;
      low_q  <= 1'b0;
    end else if (state_q == S_CHECK) begin
      high_q <= (guess_q > secret_q);
      low_q  <= (guess_q < secret_q);
    end
  end

  assign too_high_o = high_q;
  assign too_low_o  = low_q;
`else
  assign too_high_o = 1'b0;
  assign too_low_o  = 1'b0;
`endif

  assign lfsr_enable_o  = lfsr_en_q;
  assign guess_ready_o  = ready_q;
  assign result_valid_o = rv_q;
  assign match_o        = match_q;
  assign unlocked_o     = unlocked_q;
  assign locked_out_o   = locked_q;
  assign tries_left_o   = tries_q;

endmodule

// File: tb/tb_code_guess_controller.sv
// Scoreboard bench for code_guess_controller: expected compare results are queued at handshake time
// and popped by an independent monitor whenever result_valid is seen.
module tb_code_guess_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] rand_in;
  logic       lfsr_enable;
  logic       guess_valid;
  logic [7:0] guess;
  logic       guess_ready;
  logic       result_valid;
  logic       match;
  logic       too_high;
  logic       too_low;
  logic       unlocked;
  logic       locked_out;
  logic [1:0] tries_left;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       m;
    logic       th;
    logic       tl;
    logic [1:0] tries;
  } exp_t;

  exp_t sb_q[$];

  code_guess_controller #(.MAX_TRIES(3), .LOCKOUT_CYCLES(16)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_i       (start),
    .rand_in_i     (rand_in),
    .lfsr_enable_o (lfsr_enable),
    .guess_valid_i (guess_valid),
    .guess_i       (guess),
    .guess_ready_o (guess_ready),
    .result_valid_o(result_valid),
    .match_o       (match),
    .too_high_o    (too_high),
    .too_low_o     (too_low),
    .unlocked_o    (unlocked),
    .locked_out_o  (locked_out),
    .tries_left_o  (tries_left)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_lfsr_en"},  lfsr_enable,  1);
    chk({tag, "_ready"},    guess_ready,  0);
    chk({tag, "_rv"},       result_valid, 0);
    chk({tag, "_match"},    match,        0);
    chk({tag, "_hints"},    {too_high, too_low}, 0);
    chk({tag, "_unlocked"}, unlocked,     0);
    chk({tag, "_locked"},   locked_out,   0);
    chk({tag, "_tries"},    tries_left,   0);
  endtask

  // Expected hints depend on the build; without HINT_EN they must stay 0.
  function automatic exp_t mk_exp(input logic [7:0] g, input logic [7:0] s, input logic [1:0] t);
    exp_t e;
    e.m = (g == s);
`ifdef HINT_EN
    e.th = (g > s);
    e.tl = (g < s);
`else
    e.th = 1'b0;
    e.tl = 1'b0;
`endif
    e.tries = t;
    return e;
  endfunction

  // Waits (bounded) for guess_ready, performs one handshake, returns in the result cycle.
  task automatic do_guess(input logic [7:0] g, input logic [7:0] s, input logic [1:0] t_after);
    int n = 0;
    while (!guess_ready && n < 20) begin
      tick();
      n++;
    end
    chk("guess_ready_wait", guess_ready, 1);
    sb_q.push_back(mk_exp(g, s, t_after));
    guess_valid = 1'b1;
    guess       = g;
    tick();
    guess_valid = 1'b0;
    chk("ready_low_in_check", guess_ready, 0);
    tick();
  endtask

  // Monitor: independent of stimulus, compares every result pulse against the queue head.
  always @(negedge clk) begin
    if (rst_n && result_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_match", match,      e.m);
        chk("sb_high",  too_high,   e.th);
        chk("sb_low",   too_low,    e.tl);
        chk("sb_tries", tries_left, e.tries);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst_n = 1'b0; start = 1'b0; rand_in = 8'h00; guess_valid = 1'b0; guess = 8'h00;
    repeat (3) tick();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    tick();

    // Arm with A5; guess_ready appears two cycles after start is sampled
    start = 1'b1; rand_in = 8'hA5;
    tick();
    start = 1'b0;
    chk("arm_ready_low", guess_ready, 0);
    chk("arm_lfsr_en",   lfsr_enable, 1);
    tick();
    chk("wait_ready",   guess_ready, 1);
    chk("wait_tries",   tries_left,  3);
    chk("wait_lfsr_en", lfsr_enable, 0);

    // Correct first guess
    do_guess(8'hA5, 8'hA5, 2'd2);
    chk("rv_pulse",      result_valid, 1);
    chk("unlocked",      unlocked,     1);
    chk("unl_lfsr_en",   lfsr_enable,  1);
    tick();
    chk("rv_one_cycle",  result_valid, 0);
    chk("match_holds",   match,        1);

    // Re-arm clears match
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rearm_match_clr", match,    0);
    chk("rearm_unlocked",  unlocked, 0);
    tick();
    chk("rearm_tries", tries_left, 3);

    // Wrong guesses, then lockout with start held
    do_guess(8'h10, 8'hA5, 2'd2);
    chk("ready_after_miss1", guess_ready, 1);
    do_guess(8'hF0, 8'hA5, 2'd1);
    chk("ready_after_miss2", guess_ready, 1);
    do_guess(8'h20, 8'hA5, 2'd0);
    chk("lockout_enter", locked_out, 1);
    start = 1'b1;
    cnt = 0;
    while (locked_out && cnt < 100) begin
      chk("lockout_no_ready", guess_ready, 0);
      cnt++;
      tick();
    end
    chk("lockout_len",      cnt,         16);
    chk("idle_lfsr_en",     lfsr_enable, 1);
    chk("idle_not_ready",   guess_ready, 0);

    // Zero LFSR values hold ARM for three cycles
    rand_in = 8'h00;
    tick();
    start = 1'b0;
    chk("zero_arm1_ready", guess_ready, 0);
    chk("zero_arm1_lfsr",  lfsr_enable, 1);
    tick();
    chk("zero_arm2_ready", guess_ready, 0);
    tick();
    chk("zero_arm3_ready", guess_ready, 0);
    rand_in = 8'h3C;
    tick();
    chk("zero_then_ready", guess_ready, 1);
    chk("zero_then_tries", tries_left,  3);
    do_guess(8'h3C, 8'h3C, 2'd2);
    chk("zero_unlocked", unlocked, 1);

    // start beats a simultaneous guess; the guess is dropped
    rand_in = 8'h77; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("abort_pre_ready", guess_ready, 1);
    start = 1'b1; guess_valid = 1'b1; guess = 8'h77;
    tick();
    start = 1'b0; guess_valid = 1'b0;
    chk("abort_ready_low", guess_ready,  0);
    chk("abort_no_rv1",    result_valid, 0);
    tick();
    chk("abort_no_rv2",    result_valid, 0);
    chk("abort_rearmed",   guess_ready,  1);
    chk("abort_tries",     tries_left,   3);

    // Reset asserted mid-CHECK takes effect without a clock edge
    guess_valid = 1'b1; guess = 8'h77;
    tick();
    guess_valid = 1'b0;
    chk("pre_rst_check_ready", guess_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    repeat (2) tick();
    chk_reset_vals("held_rst");
    rst_n = 1'b1;
    repeat (3) tick();
    chk("sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
